// File: rtl/ps2_key_event.sv
// ps2_key_event: turns a set-2 scan-code byte stream into key events buffered in a FWFT FIFO.
// Optional macro KBD_ASCII_EN adds a per-event ASCII lookup stored alongside each entry.
module ps2_key_event #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic [7:0]       ev_ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic             overflow,
  output logic [1:0]       dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KBD_ASCII_EN
  localparam int EW = 19;
`else
  localparam int EW = 11;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} state_e;

  state_e           state_q, state_d;
  logic             emit, emit_ext, emit_brk;
  logic             held_q, held_d, last_ext_q, last_ext_d, is_rep;
  logic [7:0]       last_code_q, last_code_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             empty, full, push, pop;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    wr_entry, head;

  // Prefix decoder; 00/FF are keyboard error codes and abort any partial sequence.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (in_valid) begin
      if (in_data == 8'h00 || in_data == 8'hFF) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_data == 8'hE0)      state_d = EXT;
            else if (in_data == 8'hF0) state_d = BRK;
            else                       emit = 1'b1;
          end
          EXT: begin
            if (in_data == 8'hF0)      state_d = EXT_BRK;
            else if (in_data != 8'hE0) begin
              emit = 1'b1; emit_ext = 1'b1; state_d = IDLE;
            end
          end
          BRK: begin
            if (in_data == 8'hE0)      state_d = EXT;
            else if (in_data != 8'hF0) begin
              emit = 1'b1; emit_brk = 1'b1; state_d = IDLE;
            end
          end
          default: begin
            if (in_data != 8'hE0 && in_data != 8'hF0) begin
              emit = 1'b1; emit_ext = 1'b1; emit_brk = 1'b1; state_d = IDLE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    held_d      = held_q;
    last_code_d = last_code_q;
    last_ext_d  = last_ext_q;
    press_cnt_d = press_cnt_q;
    is_rep      = 1'b0;
    if (emit && !emit_brk) begin
      is_rep      = held_q && (in_data == last_code_q) && (emit_ext == last_ext_q);
      held_d      = 1'b1;
      last_code_d = in_data;
      last_ext_d  = emit_ext;
      if (!is_rep) press_cnt_d = press_cnt_q + CNT_W'(1);
    end else if (emit && (in_data == last_code_q) && (emit_ext == last_ext_q)) begin
      held_d = 1'b0;
    end
  end

`ifdef KBD_ASCII_EN
  function automatic logic [7:0] ascii_of(input logic [7:0] code);
    case (code)
      8'h1C: ascii_of = 8'h61; 8'h32: ascii_of = 8'h62; 8'h21: ascii_of = 8'h63;
      8'h23: ascii_of = 8'h64; 8'h24: ascii_of = 8'h65; 8'h2B: ascii_of = 8'h66;
      8'h34: ascii_of = 8'h67; 8'h33: ascii_of = 8'h68; 8'h43: ascii_of = 8'h69;
      8'h3B: ascii_of = 8'h6A; 8'h42: ascii_of = 8'h6B; 8'h4B: ascii_of = 8'h6C;
      8'h3A: ascii_of = 8'h6D; 8'h31: ascii_of = 8'h6E; 8'h44: ascii_of = 8'h6F;
      8'h4D: ascii_of = 8'h70; 8'h15: ascii_of = 8'h71; 8'h2D: ascii_of = 8'h72;
      8'h1B: ascii_of = 8'h73; 8'h2C: ascii_of = 8'h74; 8'h3C: ascii_of = 8'h75;
      8'h2A: ascii_of = 8'h76; 8'h1D: ascii_of = 8'h77; 8'h22: ascii_of = 8'h78;
      8'h35: ascii_of = 8'h79; 8'h1A: ascii_of = 8'h7A;
      8'h45: ascii_of = 8'h30; 8'h16: ascii_of = 8'h31; 8'h1E: ascii_of = 8'h32;
      8'h26: ascii_of = 8'h33; 8'h25: ascii_of = 8'h34; 8'h2E: ascii_of = 8'h35;
      8'h36: ascii_of = 8'h36; 8'h3D: ascii_of = 8'h37; 8'h3E: ascii_of = 8'h38;
      8'h46: ascii_of = 8'h39;
      8'h29: ascii_of = 8'h20; 8'h5A: ascii_of = 8'h0D; 8'h66: ascii_of = 8'h08;
      default: ascii_of = 8'h00;
    endcase
  endfunction

  assign wr_entry = {(emit_ext ? 8'h00 : ascii_of(in_data)), is_rep, emit_brk, emit_ext, in_data};
  assign ev_ascii = ev_valid ? head[18:11] : 8'h00;
`else
  assign wr_entry = {is_rep, emit_brk, emit_ext, in_data};
  assign ev_ascii = 8'h00;
`endif

  // Handshake: an event transfers on a rising edge where ev_valid && ev_ready;
  // ev_* hold steady while ev_valid && !ev_ready.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && ev_ready;
  assign push  = emit && (!full || pop);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    overflow_d = overflow_q | (emit & full & ~pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      held_q      <= 1'b0;
      last_code_q <= 8'h00;
      last_ext_q  <= 1'b0;
      press_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      last_code_q <= last_code_d;
      last_ext_q  <= last_ext_d;
      press_cnt_q <= press_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: outputs are gated by ev_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign ev_valid    = !empty;
  assign ev_code     = ev_valid ? head[7:0] : 8'h00;
  assign ev_ext      = ev_valid & head[8];
  assign ev_break    = ev_valid & head[9];
  assign ev_repeat   = ev_valid & head[10];
  assign press_cnt   = press_cnt_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Bench for ps2_key_event: directed scenarios plus random byte streams checked
// against a prefix-flag/queue reference model.
module tb_ps2_key_event;

  localparam int DEPTH = 8;

  logic       clk, reset, in_valid, ev_ready;
  logic [7:0] in_data;
  logic       ev_valid, ev_ext, ev_break, ev_repeat, overflow;
  logic [7:0] ev_code, ev_ascii, press_cnt;
  logic [1:0] dbg_state;

  ps2_key_event #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_repeat(ev_repeat), .ev_ascii(ev_ascii),
    .press_cnt(press_cnt), .overflow(overflow), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: pending-prefix flags, held-key tracker, expected event queue
  logic        m_ext_seen, m_brk_seen, m_held, m_last_ext, m_ovf;
  logic [7:0]  m_last_code;
  int          m_cnt;
  logic [18:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ascii_ref(input logic [7:0] code);
    logic [7:0] r;
    r = 8'h00;
`ifdef KBD_ASCII_EN
    begin
      logic [7:0] letters[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                  8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                  8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
      logic [7:0] digits[10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
      for (int i = 0; i < 26; i++) if (letters[i] == code) r = 8'h61 + 8'(i);
      for (int i = 0; i < 10; i++) if (digits[i] == code) r = 8'h30 + 8'(i);
      if (code == 8'h29) r = 8'h20;
      if (code == 8'h5A) r = 8'h0D;
      if (code == 8'h66) r = 8'h08;
    end
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_ext_seen = 0; m_brk_seen = 0; m_held = 0; m_last_ext = 0; m_ovf = 0;
    m_last_code = 8'h00; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_emit(input logic [7:0] code, input logic ext, input logic brk);
    logic rep;
    rep = 1'b0;
    if (!brk) begin
      rep = m_held && code == m_last_code && ext == m_last_ext;
      m_held = 1; m_last_code = code; m_last_ext = ext;
      if (!rep) m_cnt++;
    end else if (code == m_last_code && ext == m_last_ext) begin
      m_held = 0;
    end
    if (exp_q.size() < DEPTH) exp_q.push_back({code, ext, brk, rep, ext ? 8'h00 : ascii_ref(code)});
    else m_ovf = 1;
  endtask

  // Effect of one rising edge given the inputs applied before it.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic rdy);
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (v) begin
      if (d == 8'h00 || d == 8'hFF) begin
        m_ext_seen = 0; m_brk_seen = 0;
      end else if (d == 8'hE0) begin
        if (m_brk_seen && !m_ext_seen) m_brk_seen = 0;
        m_ext_seen = 1;
      end else if (d == 8'hF0) begin
        m_brk_seen = 1;
      end else begin
        model_emit(d, m_ext_seen, m_brk_seen);
        m_ext_seen = 0; m_brk_seen = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [18:0] got, want;
    got  = {ev_code, ev_ext, ev_break, ev_repeat, ev_ascii};
    want = (exp_q.size() > 0) ? exp_q[0] : 19'h0;
    check("ev_valid", 32'(ev_valid), 32'(exp_q.size() > 0));
    check("event", 32'(got), 32'(want));
    check("press_cnt", 32'(press_cnt), 32'(m_cnt[7:0]));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic step(input logic v, input logic [7:0] d, input logic rdy);
    compare_all();
    in_valid = v; in_data = d; ev_ready = rdy;
    model_edge(v, d, rdy);
    @(negedge clk);
  endtask

  task automatic send_bytes(input logic [63:0] bytes, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, bytes[8*(n-1-i) +: 8], rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    model_reset();
    #1;
    compare_all();
    check("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] pool[6] = '{8'h1C, 8'h32, 8'h75, 8'h45, 8'h29, 8'h5A};

  initial begin
    int r, phase_rdy;
    logic v, rdy;
    logic [7:0] b;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; ev_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // make/break of 'a'
    send_bytes(64'h1CF01C, 3, 1'b1);
    idle(4, 1'b1);
    check("t1_press_cnt", 32'(press_cnt), 32'd1);

    // extended make/break
    do_reset();
    send_bytes(64'hE075E0F075, 5, 1'b1);
    idle(4, 1'b1);
    check("t2_press_cnt", 32'(press_cnt), 32'd1);

    // typematic repeat, release, fresh press
    do_reset();
    send_bytes(64'h1C1C1CF01C, 5, 1'b1);
    idle(3, 1'b1);
    check("t3_press_cnt", 32'(press_cnt), 32'd1);
    send_bytes(64'h1C, 1, 1'b1);
    idle(3, 1'b1);
    check("t3_press_cnt2", 32'(press_cnt), 32'd2);

    // fill past capacity, then push+pop while full
    do_reset();
    send_bytes(64'h151D242D2C353C43, 8, 1'b0);
    send_bytes(64'h44, 1, 1'b0);
    idle(2, 1'b0);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_head", 32'(ev_code), 32'h15);
    send_bytes(64'h4D, 1, 1'b1);
    idle(DEPTH + 2, 1'b1);
    check("t4_press_cnt", 32'(press_cnt), 32'd10);

    // reset discards a partial E0 sequence
    do_reset();
    send_bytes(64'hE0, 1, 1'b1);
    do_reset();
    send_bytes(64'h1C, 1, 1'b0);
    check("t5_ext", 32'(ev_ext), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    idle(2, 1'b1);
    check("t5_press_cnt", 32'(press_cnt), 32'd1);

    // error byte while in BRK aborts the break
    do_reset();
    send_bytes(64'hF0001C, 3, 1'b0);
    check("t6_break", 32'(ev_break), 32'd0);
    idle(3, 1'b1);
    check("t6_press_cnt", 32'(press_cnt), 32'd1);

    // random stream
    do_reset();
    phase_rdy = 80;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) phase_rdy = (phase_rdy == 80) ? 10 : 80;
      v = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 19);
      if (r <= 2)       b = 8'hE0;
      else if (r <= 5)  b = 8'hF0;
      else if (r == 6)  b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      else if (r <= 14) b = pool[$urandom_range(0, 5)];
      else              b = 8'($urandom_range(1, 254));
      rdy = ($urandom_range(0, 99) < phase_rdy);
      step(v, b, rdy);
    end
    idle(DEPTH + 2, 1'b1);
    compare_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
